fnd_scan_controller: RTL and testbench

//  Downstream of the vending-machine core: drives the 4-digit common-anode FND.

---
 rtl/fnd_scan_controller_pkg.sv | 33 +++
 rtl/fnd_scan_controller_bin2bcd_seq.sv | 76 +++++++
 rtl/fnd_scan_controller.sv | 107 ++++++++++
 tb/tb_fnd_scan_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_scan_controller_pkg.sv
// Shared constants, converter state type and BCD helper for the FND scan controller.
package fnd_pkg;

    localparam logic [13:0] VALUE_MAX  = 14'd9999;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam logic [3:0]  AN_OFF     = 4'hF;
    localparam logic [3:0]  SHIFT_LAST = 4'd13;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for digits 0-9, dp off.
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd_in);
        logic [15:0] r;
        r = bcd_in;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per clock).
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] value,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    conv_state_t state, state_n;
    logic [13:0] bin_sr, bin_n;
    logic [15:0] bcd_sr, bcd_sr_n;
    logic [15:0] adj;
    logic [3:0]  shift_cnt, cnt_n;

    // The shift result is only complete while done is asserted (COMMIT).
    assign bcd = bcd_sr;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            shift_cnt <= '0;
        end else begin
            state     <= state_n;
            bin_sr    <= bin_n;
            bcd_sr    <= bcd_sr_n;
            shift_cnt <= cnt_n;
        end
    end

    // Next-state, shift datapath and status outputs.
    always_comb begin
        state_n  = state;
        bin_n    = bin_sr;
        bcd_sr_n = bcd_sr;
        cnt_n    = shift_cnt;
        adj      = dabble_adjust(bcd_sr);
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    bin_n    = (value > VALUE_MAX) ? VALUE_MAX : value;
                    bcd_sr_n = '0;
                    cnt_n    = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                bcd_sr_n = {adj[14:0], bin_sr[13]};
                bin_n    = {bin_sr[12:0], 1'b0};
                cnt_n    = shift_cnt + 4'd1;
                if (shift_cnt == SHIFT_LAST) begin
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND driver: BCD conversion, digit scan, blanking, animation override.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        anim_active,
    input  logic [7:0]  anim_seg,
    input  logic [3:0]  anim_an,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [13:0]   last_value;
    logic          start;
    logic          conv_busy;
    logic          conv_done;
    logic [15:0]   conv_bcd;
    logic [15:0]   disp;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [3:0]    digit;
    logic [15:0]   upper;
    logic          blank;
    logic [7:0]    seg_d;
    logic [3:0]    an_d;

    // The converter only accepts start while idle, so last_value tracks the
    // raw input of the conversion in flight; a change during conversion leaves
    // start high and is picked up on the first idle cycle.
    assign start = (value != last_value);
    assign busy  = conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .value (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Remember the raw value that was handed to the converter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_value <= '0;
        end else if (start && !conv_busy) begin
            last_value <= value;
        end
    end

    // Display register: all four digits replaced together on commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp <= '0;
        end else if (conv_done) begin
            disp <= conv_bcd;
        end
    end

    // Dwell counter and digit index (idx 0 = ones).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit decode with leading-zero blanking, then animation override.
    always_comb begin
        digit = disp[{idx, 2'b00} +: 4];
        upper = disp >> {idx, 2'b00};
        blank = BLANK_LZ && (idx != 2'd0) && (upper == '0);
        seg_d = blank ? SEG_BLANK : SEG_DIGIT[digit];
        an_d  = ~(4'b0001 << idx);
        if (anim_active) begin
            seg_d = anim_seg;
            an_d  = anim_an;
        end
    end

    // Registered FND drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized self-checking bench for fnd_scan_controller with a number-level reference model.
module tb_fnd_scan_controller;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        reset;
    logic [13:0] value;
    logic        anim_active;
    logic [7:0]  anim_seg;
    logic [3:0]  anim_an;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        busy;

    int n_chk;
    int n_err;

    // Reference model state: displayed number, conversion in flight, edge count.
    int          m_k;
    logic [13:0] m_last;
    int          m_disp;
    int          m_target;
    int          m_commit;
    bit          m_conv;

    logic [7:0] seg_tab [10];
    logic [7:0] cap [4];

    fnd_scan_controller #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .anim_active (anim_active),
        .anim_seg    (anim_seg),
        .anim_an     (anim_an),
        .seg         (seg),
        .an          (an),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, m_k);
        end
    endtask

    function automatic logic [7:0] model_seg(input int n, input int pos);
        int p;
        p = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (pos > 0 && n < p) return 8'hFF;
        return seg_tab[(n / p) % 10];
    endfunction

    task automatic model_reset();
        m_k      = 0;
        m_last   = '0;
        m_disp   = 0;
        m_target = 0;
        m_commit = 0;
        m_conv   = 1'b0;
    endtask

    // One clock: predict outputs from pre-edge state, advance model, compare.
    task automatic step();
        int         pos;
        logic [7:0] es;
        logic [3:0] ea;
        @(posedge clk);
        pos = (m_k / SCAN_DIV) % 4;
        if (anim_active) begin
            es = anim_seg;
            ea = anim_an;
        end else begin
            ea = ~(4'b0001 << pos);
            es = model_seg(m_disp, pos);
        end
        if (m_conv) begin
            if (m_k == m_commit) begin
                m_disp = m_target;
                m_conv = 1'b0;
            end
        end else if (value != m_last) begin
            m_last   = value;
            m_target = (value > 14'd9999) ? 9999 : int'(value);
            m_commit = m_k + 15;
            m_conv   = 1'b1;
        end
        m_k++;
        #1;
        check_eq("seg", {8'h00, seg}, {8'h00, es});
        check_eq("an", {12'h000, an}, {12'h000, ea});
        check_eq("busy", {15'h0000, busy}, {15'h0000, m_conv});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run one full refresh, recording the segments seen on each digit.
    task automatic capture_scan();
        for (int d = 0; d < 4; d++) cap[d] = 8'hxx;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            step();
            for (int d = 0; d < 4; d++) begin
                if (an == ~(4'b0001 << d)) cap[d] = seg;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"}, {8'h00, seg}, 16'h00FF);
        check_eq({tag, "_an"}, {12'h000, an}, 16'h000F);
        check_eq({tag, "_busy"}, {15'h0000, busy}, 16'h0000);
    endtask

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        n_chk = 0;
        n_err = 0;
        model_reset();
        reset       = 1'b1;
        value       = '0;
        anim_active = 1'b0;
        anim_seg    = 8'hFF;
        anim_an     = 4'hF;

        // Reset state, then value 0: ones digit shows 0, others blank.
        #1;
        check_reset_outputs("rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst_hold");
        end
        #3;
        reset = 1'b0;
        model_reset();
        steps(3 * 4 * SCAN_DIV);

        // 0 -> 1234, then one full scan shows 4,3,2,1 on an=E,D,B,7.
        value = 14'd1234;
        steps(20);
        capture_scan();
        check_eq("d1234_0", {8'h00, cap[0]}, 16'h0099);
        check_eq("d1234_1", {8'h00, cap[1]}, 16'h00B0);
        check_eq("d1234_2", {8'h00, cap[2]}, 16'h00A4);
        check_eq("d1234_3", {8'h00, cap[3]}, 16'h00F9);

        // Change mid-conversion: 300 completes, then 200 follows.
        value = 14'd300;
        steps(6);
        value = 14'd200;
        steps(45);

        // Clamp above 9999, then a single lit digit.
        value = 14'd12000;
        steps(20);
        capture_scan();
        for (int d = 0; d < 4; d++) check_eq("clamp", {8'h00, cap[d]}, 16'h0090);
        value = 14'd5;
        steps(20);
        capture_scan();
        check_eq("five_0", {8'h00, cap[0]}, 16'h0092);
        for (int d = 1; d < 4; d++) check_eq("five_blank", {8'h00, cap[d]}, 16'h00FF);

        // Animation override and resume.
        anim_active = 1'b1;
        anim_seg    = 8'hFE;
        anim_an     = 4'h0;
        step();
        for (int i = 0; i < 6; i++) begin
            anim_seg = 8'($urandom);
            anim_an  = 4'($urandom);
            step();
        end
        anim_active = 1'b0;
        steps(2 * 4 * SCAN_DIV);

        // Reset during SHIFT; the held value is reconverted after release.
        value = 14'd777;
        steps(5);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst_mid_hold");
        end
        #3;
        reset = 1'b0;
        model_reset();
        steps(20);
        capture_scan();
        check_eq("r777_0", {8'h00, cap[0]}, 16'h00F8);
        check_eq("r777_3", {8'h00, cap[3]}, 16'h00FF);

        // Randomized traffic on value and override.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 1) == 0) value = 14'($urandom_range(0, 16383));
                else value = 14'($urandom_range(0, 120));
            end
            if ($urandom_range(0, 39) == 0) anim_active = ~anim_active;
            anim_seg = 8'($urandom);
            anim_an  = 4'($urandom);
            step();
        end
        anim_active = 1'b0;
        steps(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
